// File: rtl/fl_recover_pkg.sv
// Shared types and helpers for the freelist recovery sequencer.
package fl_recover_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } fl_rec_state_e;

  localparam int FL_SCAN_LANES = 2;

  // Wide enough to hold the value FREE_REG itself, not just FREE_REG-1.
  function automatic int fl_cnt_width(input int free_reg);
    return $clog2(free_reg) + 1;
  endfunction

endpackage

// File: rtl/fl_scan_pick.sv
// Picks up to two free registers from a pair, packing lane 0 first and
// never granting more pushes than the remaining freelist room.
module fl_scan_pick
  import fl_recover_pkg::*;
#(
  parameter int PHY_WIDTH = 6,
  parameter int CNT_W     = 6
) (
  input  logic [1:0]               i_used,
  input  logic [PHY_WIDTH-1:0]     i_base,
  input  logic [CNT_W-1:0]         i_room,
  output logic [FL_SCAN_LANES-1:0] o_valid,
  output logic [PHY_WIDTH-1:0]     o_phy_0,
  output logic [PHY_WIDTH-1:0]     o_phy_1
);

  logic w_room_1;
  logic w_room_2;

  assign w_room_1 = (i_room != '0);
  assign w_room_2 = (i_room >= CNT_W'(2));

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_valid = '0;
    o_phy_0 = '0;
    o_phy_1 = '0;
    unique case (i_used)
      2'b00: begin
        if (w_room_2) begin
          o_valid = 2'b11;
          o_phy_0 = i_base;
          o_phy_1 = i_base + PHY_WIDTH'(1);
        end else if (w_room_1) begin
          o_valid = 2'b01;
          o_phy_0 = i_base;
        end
      end
      2'b10: begin
        if (w_room_1) begin
          o_valid = 2'b01;
          o_phy_0 = i_base;
        end
      end
      2'b01: begin
        if (w_room_1) begin
          o_valid = 2'b01;
          o_phy_0 = i_base + PHY_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/freelist_recovery_ctrl.sv
// Rebuilds the rename freelist after a flush: clear, then scan two regs/cycle.
// Optional feature macro: FL_RECOVER_CHECK_EN (sticky push-count error flag).
module freelist_recovery_ctrl
  import fl_recover_pkg::*;
#(
  parameter int PHY_REGS  = 64,
  parameter int PHY_WIDTH = 6,
  parameter int FREE_REG  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [PHY_REGS-1:0]      arch_map_used,
  output logic                     fl_clear,
  output logic [FL_SCAN_LANES-1:0] fl_push_valid,
  output logic [PHY_WIDTH-1:0]     fl_push_phy_0,
  output logic [PHY_WIDTH-1:0]     fl_push_phy_1,
  output logic                     rename_stall,
  output logic                     recover_done,
  output logic                     recover_err
);

  localparam int CNT_W = fl_cnt_width(FREE_REG);

  fl_rec_state_e               r_state;
  fl_rec_state_e               w_next_state;
  logic [PHY_WIDTH-1:0]        r_idx;
  logic [CNT_W-1:0]            r_push_cnt;
  logic [PHY_REGS-1:0]         r_used_snap;
  logic [1:0]                  w_used;
  logic [CNT_W-1:0]            w_room;
  logic [FL_SCAN_LANES-1:0]    w_valid;
  logic [PHY_WIDTH-1:0]        w_phy_0;
  logic [PHY_WIDTH-1:0]        w_phy_1;
  logic                        w_last;

  assign w_used = {r_used_snap[{r_idx[PHY_WIDTH-1:1], 1'b1}], r_used_snap[r_idx]};
  // Zero room outside SCAN keeps the picker silent in every other state.
  assign w_room = (r_state == SCAN) ? (CNT_W'(FREE_REG) - r_push_cnt) : '0;
  assign w_last = (r_idx == PHY_WIDTH'(PHY_REGS - 2));

  fl_scan_pick #(
    .PHY_WIDTH (PHY_WIDTH),
    .CNT_W     (CNT_W)
  ) u_pick (
    .i_used  (w_used),
    .i_base  (r_idx),
    .i_room  (w_room),
    .o_valid (w_valid),
    .o_phy_0 (w_phy_0),
    .o_phy_1 (w_phy_1)
  );

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = CLEAR;
    end else begin
      unique case (r_state)
        IDLE:    w_next_state = IDLE;
        CLEAR:   w_next_state = SCAN;
        SCAN:    w_next_state = w_last ? DONE : SCAN;
        DONE:    w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_push_cnt  <= '0;
      // NOTE: the snapshot is a plain register vector, so resetting it to
      // "all held" is cheap and keeps a stray scan from freeing anything.
      r_used_snap <= '1;
    end else begin
      r_state <= w_next_state;
      if (flush) begin
        r_used_snap <= arch_map_used | {{(PHY_REGS-1){1'b0}}, 1'b1};
        r_idx       <= '0;
        r_push_cnt  <= '0;
      end else if (r_state == SCAN) begin
        r_idx      <= r_idx + PHY_WIDTH'(2);
        r_push_cnt <= r_push_cnt + CNT_W'(w_valid[0]) + CNT_W'(w_valid[1]);
      end
    end
  end

  assign fl_clear      = (r_state == CLEAR);
  assign fl_push_valid = w_valid;
  assign fl_push_phy_0 = w_phy_0;
  assign fl_push_phy_1 = w_phy_1;
  assign rename_stall  = flush | (r_state != IDLE);
  assign recover_done  = (r_state == DONE) & ~flush;

`ifdef FL_RECOVER_CHECK_EN
  logic r_err;
  logic w_drop;
  logic w_short;

  // A free candidate that the picker did not grant was suppressed by the limit.
  assign w_drop  = (r_state == SCAN) &&
                   (({1'b0, ~w_used[0]} + {1'b0, ~w_used[1]}) !=
                    ({1'b0, w_valid[0]} + {1'b0, w_valid[1]}));
  assign w_short = (r_state == DONE) && !flush && (r_push_cnt != CNT_W'(FREE_REG));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_drop || w_short) begin
      r_err <= 1'b1;
    end
  end

  assign recover_err = r_err;
`else
  assign recover_err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_recovery_ctrl.sv
// Directed bench for freelist_recovery_ctrl at default parameters.
module tb_freelist_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] arch_map_used;
  logic        fl_clear;
  logic [1:0]  fl_push_valid;
  logic [5:0]  fl_push_phy_0;
  logic [5:0]  fl_push_phy_1;
  logic        rename_stall;
  logic        recover_done;
  logic        recover_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] MAP_HALF   = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MAP_SPARSE = 64'h5555_5555_5555_5555;

`ifdef FL_RECOVER_CHECK_EN
  localparam logic OVF_ERR = 1'b1;
`else
  localparam logic OVF_ERR = 1'b0;
`endif

  freelist_recovery_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .arch_map_used (arch_map_used),
    .fl_clear      (fl_clear),
    .fl_push_valid (fl_push_valid),
    .fl_push_phy_0 (fl_push_phy_0),
    .fl_push_phy_1 (fl_push_phy_1),
    .rename_stall  (rename_stall),
    .recover_done  (recover_done),
    .recover_err   (recover_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {clear, valid[1:0], phy0, phy1, stall, done}
  function automatic logic [16:0] obs();
    return {fl_clear, fl_push_valid, fl_push_phy_0, fl_push_phy_1, rename_stall, recover_done};
  endfunction

  function automatic logic [16:0] mk(input logic clr, input logic [1:0] v, input logic [5:0] p0,
                                     input logic [5:0] p1, input logic st, input logic dn);
    return {clr, v, p0, p1, st, dn};
  endfunction

  function automatic logic [16:0] exp_sparse(input int k);
    return mk(1'b0, 2'b01, 6'(2 * k + 1), 6'd0, 1'b1, 1'b0);
  endfunction

  function automatic logic [16:0] exp_half(input int k);
    return (k >= 16) ? mk(1'b0, 2'b11, 6'(2 * k), 6'(2 * k + 1), 1'b1, 1'b0)
                     : mk(1'b0, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
  endfunction

  task automatic test_reset;
    logic [16:0] e;
    rst = 1'b0; flush = 1'b1; arch_map_used = '0;
    tick; tick;
    e = mk(1'b0, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", obs(), e);
    end
    n_checks++;
    if (recover_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got=%b want=0", recover_err);
    end
    flush = 1'b0; #1;
    n_checks++;
    if (rename_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall_follows_flush got=%b want=0", rename_stall);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++;
      if (obs() !== 17'd0) begin
        n_fail++; $display("FAIL idle_no_flush cyc=%0d got=%h want=0", i, obs());
      end
    end
  endtask

  task automatic test_half_map;
    logic [16:0] e;
    int pushes = 0;
    arch_map_used = MAP_HALF; flush = 1'b1; #1;
    e = mk(1'b0, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL half_flush_cycle got=%h want=%h", obs(), e);
    end
    tick; flush = 1'b0; #1;
    e = mk(1'b1, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL half_clear got=%h want=%h", obs(), e);
    end
    for (int k = 0; k < 32; k++) begin
      tick;
      e = exp_half(k);
      pushes += int'(fl_push_valid[0]) + int'(fl_push_valid[1]);
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL half_scan k=%0d got=%h want=%h", k, obs(), e);
      end
    end
    tick;
    e = mk(1'b0, 2'b00, 6'd0, 6'd0, 1'b1, 1'b1);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL half_done got=%h want=%h", obs(), e);
    end
    n_checks++;
    if (recover_err !== 1'b0) begin
      n_fail++; $display("FAIL half_err got=%b want=0", recover_err);
    end
    tick;
    n_checks++;
    if (obs() !== 17'd0) begin
      n_fail++; $display("FAIL half_idle_after got=%h want=0", obs());
    end
    n_checks++;
    if (pushes !== 32) begin
      n_fail++; $display("FAIL half_push_total got=%0d want=32", pushes);
    end
  endtask

  task automatic test_sparse;
    logic [16:0] e;
    int pushes = 0;
    arch_map_used = MAP_SPARSE; flush = 1'b1;
    tick; flush = 1'b0; #1;
    n_checks++;
    if (fl_clear !== 1'b1) begin
      n_fail++; $display("FAIL sparse_clear got=%b want=1", fl_clear);
    end
    for (int k = 0; k < 32; k++) begin
      tick;
      e = exp_sparse(k);
      pushes += int'(fl_push_valid[0]) + int'(fl_push_valid[1]);
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL sparse_scan k=%0d got=%h want=%h", k, obs(), e);
      end
    end
    tick;
    n_checks++;
    if ({recover_done, recover_err} !== 2'b10) begin
      n_fail++; $display("FAIL sparse_done_err got=%b%b want=10", recover_done, recover_err);
    end
    tick;
    n_checks++;
    if (pushes !== 32) begin
      n_fail++; $display("FAIL sparse_push_total got=%0d want=32", pushes);
    end
  endtask

  task automatic test_restart;
    logic [16:0] e;
    int pushes = 0;
    arch_map_used = MAP_HALF; flush = 1'b1;
    tick; flush = 1'b0;
    for (int k = 0; k <= 10; k++) tick;
    arch_map_used = MAP_SPARSE; flush = 1'b1; #1;
    e = exp_half(10);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL restart_cycle got=%h want=%h", obs(), e);
    end
    tick; flush = 1'b0; arch_map_used = '0; #1;
    e = mk(1'b1, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL restart_clear got=%h want=%h", obs(), e);
    end
    for (int k = 0; k < 32; k++) begin
      tick;
      e = exp_sparse(k);
      pushes += int'(fl_push_valid[0]) + int'(fl_push_valid[1]);
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL restart_scan k=%0d got=%h want=%h", k, obs(), e);
      end
    end
    tick;
    n_checks++;
    if (recover_done !== 1'b1) begin
      n_fail++; $display("FAIL restart_done got=%b want=1", recover_done);
    end
    tick;
    n_checks++;
    if (pushes !== 32) begin
      n_fail++; $display("FAIL restart_push_total got=%0d want=32", pushes);
    end
  endtask

  task automatic test_done_restart;
    logic [16:0] e;
    arch_map_used = MAP_SPARSE; flush = 1'b1;
    tick; flush = 1'b0;
    for (int k = 0; k < 32; k++) tick;
    tick;
    arch_map_used = '0; flush = 1'b1; #1;
    e = mk(1'b0, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL done_restart_suppress got=%h want=%h", obs(), e);
    end
    tick; flush = 1'b0; #1;
    n_checks++;
    if (fl_clear !== 1'b1) begin
      n_fail++; $display("FAIL done_restart_clear got=%b want=1", fl_clear);
    end
    tick;
    e = mk(1'b0, 2'b01, 6'd1, 6'd0, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL done_restart_phys0_held got=%h want=%h", obs(), e);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
  endtask

  task automatic test_overflow;
    logic [16:0] e;
    int pushes = 0;
    arch_map_used = 64'h1; flush = 1'b1;
    tick; flush = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick;
      if (k == 0)       e = mk(1'b0, 2'b01, 6'd1, 6'd0, 1'b1, 1'b0);
      else if (k < 16)  e = mk(1'b0, 2'b11, 6'(2 * k), 6'(2 * k + 1), 1'b1, 1'b0);
      else if (k == 16) e = mk(1'b0, 2'b01, 6'd32, 6'd0, 1'b1, 1'b0);
      else              e = mk(1'b0, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
      pushes += int'(fl_push_valid[0]) + int'(fl_push_valid[1]);
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL ovf_scan k=%0d got=%h want=%h", k, obs(), e);
      end
    end
    tick;
    n_checks++;
    if ({recover_done, recover_err} !== {1'b1, OVF_ERR}) begin
      n_fail++; $display("FAIL ovf_done_err got=%b%b want=1%b", recover_done, recover_err, OVF_ERR);
    end
    tick;
    n_checks++;
    if (pushes !== 32) begin
      n_fail++; $display("FAIL ovf_push_total got=%0d want=32", pushes);
    end
  endtask

  task automatic test_reset_mid;
    arch_map_used = MAP_SPARSE; flush = 1'b1;
    tick; flush = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    n_checks++;
    if (obs() !== exp_sparse(4)) begin
      n_fail++; $display("FAIL midrst_scan got=%h want=%h", obs(), exp_sparse(4));
    end
    rst = 1'b0;
    tick;
    n_checks++;
    if ({obs(), recover_err} !== 18'd0) begin
      n_fail++; $display("FAIL midrst_abort got=%h err=%b want=0", obs(), recover_err);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if (obs() !== 17'd0) begin
        n_fail++; $display("FAIL midrst_idle cyc=%0d got=%h want=0", i, obs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_half_map();
    test_sparse();
    test_restart();
    test_done_restart();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freelist_recovery_ctrl.md
# freelist_recovery_ctrl

Sequencer that rebuilds the rename freelist after a pipeline flush. On flush it snapshots the committed-map occupancy vector, clears the freelist pointers, then scans all physical registers two per cycle and pushes every unmapped one back into the freelist. While recovery runs it stalls rename. The block sits between the ROB/commit flush logic and the freelist's clear and push ports.

## Interface
- PHY_REGS, 64, number of physical registers; must be even
- PHY_WIDTH, 6, physical register index width, equal to $clog2(PHY_REGS)
- FREE_REG, 32, freelist capacity, which is the expected number of pushes per recovery
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-low
- flush  in  1  recovery request; sampled on every edge
- arch_map_used  in  PHY_REGS  bit i set means phys reg i is held by the committed map and must not be freed
- fl_clear  out  1  one-cycle pulse that resets freelist head, tail and count to empty
- fl_push_valid  out  2  per-lane push strobes; lane 0 always carries the lower index
- fl_push_phy_0  out  PHY_WIDTH  lane 0 register index
- fl_push_phy_1  out  PHY_WIDTH  lane 1 register index
- rename_stall  out  1  rename must not allocate or retire-free while this is high
- recover_done  out  1  one-cycle pulse marking the final cycle of recovery
- recover_err  out  1  sticky push-count mismatch flag (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, SCAN, DONE.
- IDLE → CLEAR on flush=1.
  - Capture used_snap <= arch_map_used, with bit 0 forced to 1 (phys 0 is never freed).
  - Set idx <= 0 and push_cnt <= 0.
- CLEAR: fl_clear=1 and no pushes. Next state is SCAN.
- SCAN: examine registers idx and idx+1.
  - Each register whose used_snap bit is 0 is a candidate.
  - Candidates pack into lane 0 first. If only idx+1 is free, it goes out on lane 0.
  - After the cycle: idx += 2 and push_cnt += number pushed.
  - When idx == PHY_REGS-2 this cycle, next state is DONE.
- DONE: recover_done=1 and no pushes. Next state is IDLE.
- Count arithmetic:
  - push_cnt is $clog2(FREE_REG)+1 bits wide.
  - A push that would make push_cnt exceed FREE_REG is suppressed, along with any later pushes in the same recovery.
  - Suppression is unconditional and does not depend on the macro.
- flush=1 in CLEAR, SCAN or DONE restarts recovery: same capture as IDLE, go to CLEAR.
  - Outputs in the restarting cycle still follow the current state.
  - recover_done is suppressed if the restart lands in DONE.
- rename_stall = flush | (state != IDLE).
- Unused lane index outputs drive 0. No X values are permitted on any output.

## Timing
- Reset (rst=0 at an edge): state IDLE, idx 0, push_cnt 0, used_snap all ones, recover_err 0.
  - Outputs: fl_clear 0, fl_push_valid 00, fl_push_phy_* 0, recover_done 0, rename_stall = flush.
- rst=0 mid-recovery aborts immediately. No done pulse is issued.
- Sequence for flush sampled at edge T:
  - Cycle T+1: CLEAR.
  - Cycles T+2 … T+1+PHY_REGS/2: SCAN (32 cycles at default parameters).
  - Next cycle: DONE.
  - Total stall is flush cycle + 34 cycles at default parameters.
- Pushes are registered-state driven and become valid in the same cycle as the SCAN state. The freelist consumes them on the following edge.
- arch_map_used is only sampled at capture. Later changes are ignored.

## Configuration
- FL_RECOVER_CHECK_EN defined:
  - recover_err is set when a push is suppressed by the FREE_REG limit.
  - recover_err is also set when push_cnt != FREE_REG in DONE.
  - It stays set until reset.
- FL_RECOVER_CHECK_EN undefined: recover_err is tied to 0 and no comparison logic is built.

## Structure
- Package fl_recover_pkg holds:
  - the fl_rec_state_e enum (IDLE, CLEAR, SCAN, DONE);
  - FL_SCAN_LANES = 2;
  - a function computing the push_cnt width from FREE_REG.
- One natural sub-module, fl_scan_pick. It is combinational and takes two used bits, a base index and a remaining-capacity count. It returns the packed lane valids and indices.

## Test plan
- Reset then no flush → all outputs idle, rename_stall 0, recover_done never pulses.
- arch_map_used = 0x0000_0000_FFFF_FFFF, flush for 1 cycle:
  - fl_clear at T+1;
  - pushes 32..63 in pairs over the last 16 SCAN cycles;
  - recover_done at T+34;
  - recover_err 0.
- Sparse map (even bits 0..62 set):
  - every SCAN cycle pushes the odd register on lane 0 only, lane 1 invalid, phy_1 = 0;
  - total 32 pushes.
- flush re-asserted at SCAN cycle 10 with a different map:
  - fl_clear re-pulses;
  - scan restarts from 0 with the new snapshot;
  - no recover_done until the new DONE.
- arch_map_used = 0x1 (63 free) with FL_RECOVER_CHECK_EN:
  - exactly 32 pushes (1..32), then pushes are suppressed;
  - recover_err = 1.
  - Without the macro: same 32 pushes, recover_err stays 0.
- rst=0 during SCAN → next cycle IDLE, no pushes, no recover_done, rename_stall 0.
